// File: rtl/mdu_hilo_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_hilo_ctrl_if
// Issue/result bus between the HI/LO control stage and the pipelined
// multiplier.
//   mul_en      ctrl -> mult  one-cycle issue pulse
//   mul_cancel  ctrl -> mult  one-cycle cancel pulse (restarts the count at 1)
//   mul_a       ctrl -> mult  33-bit extended rs operand
//   mul_b       ctrl -> mult  33-bit extended rt operand
//   mul_res     mult -> ctrl  66-bit product
//   mul_finish  mult -> ctrl  mul_res is valid this cycle
// master = control stage, slave = multiplier.
// ---------------------------------------------------------------------------
interface mdu_hilo_ctrl_if;
  logic        mul_en;
  logic        mul_cancel;
  logic [32:0] mul_a;
  logic [32:0] mul_b;
  logic [65:0] mul_res;
  logic        mul_finish;

  modport master (
    output mul_en,
    output mul_cancel,
    output mul_a,
    output mul_b,
    input  mul_res,
    input  mul_finish
  );

  modport slave (
    input  mul_en,
    input  mul_cancel,
    input  mul_a,
    input  mul_b,
    output mul_res,
    output mul_finish
  );
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_hilo_ctrl
// Multiply/accumulate control stage in EX. Decodes MDU ops, extends and
// issues operands to the pipelined multiplier, stalls EX until the product
// returns, then updates HI/LO (plain or accumulate) or returns the low word
// of a MUL to the GPR path. An EX flush cancels an in-flight multiply and the
// stage drains the multiplier before accepting new work.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   op_valid, op           MDU op held in EX (1..7 mul-class, 8 MTHI, 9 MTLO)
//   rs_val, rt_val         operands
//   flush                  exception/eret flush of EX
//   mul_if (master)        issue/cancel/operands out, product/finish in
//   stall                  hold EX and earlier stages
//   hi, lo                 architectural HI/LO
//   gpr_res, gpr_res_valid MUL result (low product word), one-cycle valid
// ---------------------------------------------------------------------------
module mdu_hilo_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  input  logic [3:0]      op,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  input  logic            flush,
  mdu_hilo_ctrl_if.master mul_if,
  output logic            stall,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic [31:0]     gpr_res,
  output logic            gpr_res_valid
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  // A cancelled multiply restarts at count 1 and finishes MUL_LAT-1 cycles
  // later; that only makes sense for a pipeline of at least two stages.
  if (MUL_LAT < 2) begin : g_lat_check
    $error("mdu_hilo_ctrl: MUL_LAT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [32:0] a_q, a_d;
  logic [32:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul_class;
  logic        is_mt;
  logic        op_signed;
  logic [32:0] rs_ext;
  logic [32:0] rt_ext;
  logic [63:0] prod;
  logic [63:0] hilo_cur;
  logic [63:0] hilo_new;
  logic        unused_res_top;

  logic        mul_en_c;
  logic        mul_cancel_c;
  logic [32:0] mul_a_c;
  logic [32:0] mul_b_c;
  logic        stall_c;
  logic        gpr_valid_c;
  logic [31:0] gpr_res_c;

  // ---------------------------------------------------------------- decode
  assign is_mul_class = (op >= OP_MULT) && (op <= OP_MUL);
  assign is_mt        = (op == OP_MTHI) || (op == OP_MTLO);
  assign op_signed    = (op == OP_MULT) || (op == OP_MADD) ||
                        (op == OP_MSUB) || (op == OP_MUL);

  // 33-bit extension lets one signed multiplier serve both signednesses.
  assign rs_ext = {op_signed & rs_val[31], rs_val};
  assign rt_ext = {op_signed & rt_val[31], rt_val};

  // Only the low 64 product bits are architecturally meaningful.
  assign prod           = mul_if.mul_res[63:0];
  assign unused_res_top = ^mul_if.mul_res[65:64];
  assign hilo_cur       = {hi_q, lo_q};

  // HI/LO value written by the latched op; accumulation wraps modulo 2^64.
  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: hilo_new = hilo_cur + prod;
      OP_MSUB, OP_MSUBU: hilo_new = hilo_cur - prod;
      default:           hilo_new = prod;
    endcase
  end

  // ------------------------------------------------- next state / outputs
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_en_c     = 1'b0;
    mul_cancel_c = 1'b0;
    mul_a_c      = a_q;
    mul_b_c      = b_q;
    stall_c      = 1'b0;
    gpr_valid_c  = 1'b0;
    gpr_res_c    = 32'd0;

    case (state_q)
      S_IDLE: begin
        mul_a_c = rs_ext;
        mul_b_c = rt_ext;
        if (op_valid && !flush) begin
          if (is_mul_class) begin
            mul_en_c = 1'b1;
            stall_c  = 1'b1;
            op_d     = op;
            a_d      = rs_ext;
            b_d      = rt_ext;
            state_d  = S_WAIT;
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end

      S_WAIT: begin
        if (mul_if.mul_finish) begin
          state_d = S_IDLE;
          // An MTHI/MTLO waiting behind the multiply is held one more cycle
          // so the product write lands first and the move overwrites it.
          stall_c = op_valid && is_mt && !flush;
          if (!flush) begin
            if (op_q == OP_MUL) begin
              gpr_valid_c = 1'b1;
              gpr_res_c   = prod[31:0];
            end else begin
              hi_d = hilo_new[63:32];
              lo_d = hilo_new[31:0];
            end
          end
        end else begin
          stall_c = 1'b1;
          if (flush) begin
            mul_cancel_c = 1'b1;
            state_d      = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // New multiplies wait for IDLE; moves proceed, flush has no effect
        // on the already-cancelled multiplier.
        stall_c = op_valid && is_mul_class;
        if (op_valid && !flush) begin
          if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
        if (mul_if.mul_finish) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Keep every strobe quiet while reset is held.
    if (!resetn) begin
      mul_en_c     = 1'b0;
      mul_cancel_c = 1'b0;
      stall_c      = 1'b0;
      gpr_valid_c  = 1'b0;
      gpr_res_c    = 32'd0;
    end
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      a_q     <= 33'd0;
      b_q     <= 33'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // -------------------------------------------------------------- outputs
  assign mul_if.mul_en     = mul_en_c;
  assign mul_if.mul_cancel = mul_cancel_c;
  assign mul_if.mul_a      = mul_a_c;
  assign mul_if.mul_b      = mul_b_c;
  assign stall             = stall_c;
  assign gpr_res_valid     = gpr_valid_c;
  assign gpr_res           = gpr_res_c;
  assign hi                = hi_q;
  assign lo                = lo_q;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_hilo_ctrl
// Self-checking bench: a behavioural multiplier drives the slave side of the
// bus, a transaction-level model predicts every output each cycle, and a few
// directed sequences pin hand-computed HI/LO/GPR values.
// ---------------------------------------------------------------------------
module tb_mdu_hilo_ctrl;
  localparam int MUL_LAT = 3;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] gpr_res;
  logic        gpr_res_valid;

  mdu_hilo_ctrl_if mif ();

  mdu_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .op_valid      (op_valid),
    .op            (op),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .flush         (flush),
    .mul_if        (mif),
    .stall         (stall),
    .hi            (hi),
    .lo            (lo),
    .gpr_res       (gpr_res),
    .gpr_res_valid (gpr_res_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on  = 1'b0;
  bit spur_on = 1'b0;

  // behavioural multiplier
  bit          env_busy = 1'b0;
  int          env_rem  = 0;
  logic [65:0] env_prod = '0;

  // reference model: one in-flight multiply, possibly abandoned by a flush
  bit          m_busy  = 1'b0;
  bit          m_drain = 1'b0;
  logic [3:0]  m_op    = '0;
  logic [63:0] m_prod  = '0;
  logic [63:0] m_hilo  = '0;
  bit          m_stall_prev = 1'b0;

  // last values seen at the sampling edge
  logic        obs_en, obs_cancel, obs_stall, obs_gv;
  logic [31:0] obs_gr;
  logic [32:0] obs_a, obs_b;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_signed_op(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB) || (o == OP_MUL);
  endfunction

  // True 64-bit product of the 32-bit operands, as the ISA defines it.
  function automatic logic [63:0] prod_of(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (is_signed_op(o)) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // One clock: drive at post-edge, compare at negedge, advance models at posedge.
  task automatic step(input bit v, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit f, input bit rn);
    bit          fin, real_fin, mulc, mtx, sgn;
    bit          e_en, e_cancel, e_stall, e_gv;
    logic [31:0] e_gr;
    logic [32:0] e_a, e_b;
    logic [63:0] nxt_hilo;
    bit          cap_en, cap_cancel;
    logic [32:0] cap_a, cap_b;
    logic signed [32:0] sa, sb;
    logic signed [65:0] sp;

    op_valid = v; op = o; rs_val = a; rt_val = b; flush = f; resetn = rn;
    real_fin = env_busy && (env_rem == 0);
    fin = real_fin || (spur_on && !env_busy && ($urandom_range(0, 7) == 0));
    mif.mul_finish = fin;
    mif.mul_res = real_fin ? env_prod : {2'($urandom_range(0, 3)), $urandom, $urandom};

    @(negedge clk);
    mulc = v && (o >= OP_MULT) && (o <= OP_MUL);
    mtx  = v && ((o == OP_MTHI) || (o == OP_MTLO));
    sgn  = is_signed_op(o);
    e_a  = sgn ? 33'(signed'(a)) : {1'b0, a};
    e_b  = sgn ? 33'(signed'(b)) : {1'b0, b};
    e_en = 0; e_cancel = 0; e_stall = 0; e_gv = 0; e_gr = '0;
    nxt_hilo = m_hilo;

    if (!rn) begin
      nxt_hilo = '0;
    end else if (!m_busy) begin
      if (mulc && !f) begin
        e_en = 1; e_stall = 1;
      end else if (mtx && !f) begin
        nxt_hilo = (o == OP_MTHI) ? {a, m_hilo[31:0]} : {m_hilo[63:32], a};
      end
    end else if (!m_drain) begin
      if (fin) begin
        e_stall = mtx && !f;
        if (!f) begin
          case (m_op)
            OP_MUL: begin e_gv = 1; e_gr = m_prod[31:0]; end
            OP_MADD, OP_MADDU: nxt_hilo = m_hilo + m_prod;
            OP_MSUB, OP_MSUBU: nxt_hilo = m_hilo - m_prod;
            default: nxt_hilo = m_prod;
          endcase
        end
      end else begin
        e_stall = 1;
        e_cancel = f;
      end
    end else begin
      e_stall = mulc;
      if (mtx && !f)
        nxt_hilo = (o == OP_MTHI) ? {a, m_hilo[31:0]} : {m_hilo[63:32], a};
    end

    if (chk_on) begin
      check("stall", stall, e_stall);
      check("mul_en", mif.mul_en, e_en);
      check("mul_cancel", mif.mul_cancel, e_cancel);
      check("gpr_res_valid", gpr_res_valid, e_gv);
      if (e_gv) check("gpr_res", gpr_res, e_gr);
      if (!rn) check("gpr_res_in_reset", gpr_res, 0);
      if (e_en) begin
        check("mul_a", mif.mul_a, e_a);
        check("mul_b", mif.mul_b, e_b);
      end
      check("hi", hi, m_hilo[63:32]);
      check("lo", lo, m_hilo[31:0]);
    end

    obs_en = mif.mul_en; obs_cancel = mif.mul_cancel; obs_stall = stall;
    obs_gv = gpr_res_valid; obs_gr = gpr_res; obs_a = mif.mul_a; obs_b = mif.mul_b;
    cap_en = (mif.mul_en === 1'b1); cap_cancel = (mif.mul_cancel === 1'b1);
    cap_a = mif.mul_a; cap_b = mif.mul_b;
    m_stall_prev = e_stall;

    @(posedge clk);
    // model
    m_hilo = nxt_hilo;
    if (!rn) begin
      m_busy = 0; m_drain = 0;
    end else if (!m_busy) begin
      if (e_en) begin
        m_busy = 1; m_drain = 0; m_op = o; m_prod = prod_of(o, a, b);
      end
    end else if (!m_drain) begin
      if (fin) m_busy = 0;
      else if (f) m_drain = 1;
    end else if (fin) begin
      m_busy = 0; m_drain = 0;
    end
    // multiplier
    if (!rn) begin
      env_busy = 0; env_rem = 0;
    end else if (cap_cancel) begin
      env_rem = MUL_LAT - 2;
    end else if (cap_en) begin
      env_busy = 1; env_rem = MUL_LAT - 1;
      sa = cap_a; sb = cap_b; sp = sa * sb; env_prod = sp;
    end else if (env_busy) begin
      if (env_rem == 0) env_busy = 0;
      else env_rem--;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 4'd0, 32'd0, 32'd0, 0, 1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit hv, hf, rn;
    logic [3:0] ho;
    logic [31:0] ha, hb;

    @(posedge clk); #1;
    step(0, 4'd0, 32'd0, 32'd0, 0, 0);
    chk_on = 1'b1;
    step(0, 4'd0, 32'd0, 32'd0, 0, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_stall", stall, 0);
    check("rst_gpr_res", gpr_res, 0);

    // MULT -3 * 5
    step(1, OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1);
    check("mult_en_T", obs_en, 1);
    check("mult_stall_T", obs_stall, 1);
    idle(1);
    check("mult_en_T1", obs_en, 0);
    check("mult_stall_T1", obs_stall, 1);
    idle(1);
    check("mult_stall_T2", obs_stall, 1);
    idle(1);
    check("mult_stall_T3", obs_stall, 0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF^2
    step(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    check("multu_a", obs_a, 33'h0_FFFF_FFFF);
    check("multu_b", obs_b, 33'h0_FFFF_FFFF);
    idle(3);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // MTHI 0, MTLO 1, MADD 2*3 -> 7
    step(1, OP_MTHI, 32'd0, 32'd0, 0, 1);
    check("mthi_nostall", obs_stall, 0);
    step(1, OP_MTLO, 32'd1, 32'd0, 0, 1);
    check("mtlo_lo", lo, 32'd1);
    step(1, OP_MADD, 32'd2, 32'd3, 0, 1);
    idle(3);
    check("madd_hi", hi, 32'd0);
    check("madd_lo", lo, 32'd7);
    // MSUBU 1*1 from zero wraps
    step(1, OP_MTLO, 32'd0, 32'd0, 0, 1);
    step(1, OP_MSUBU, 32'd1, 32'd1, 0, 1);
    idle(3);
    check("msubu_hi", hi, 32'hFFFF_FFFF);
    check("msubu_lo", lo, 32'hFFFF_FFFF);

    // MUL 0x10000 * 0x10000 -> GPR 0, HI/LO untouched
    step(1, OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, 1);
    idle(2);
    check("mul_gv_T2", obs_gv, 0);
    idle(1);
    check("mul_gv_T3", obs_gv, 1);
    check("mul_gr_T3", obs_gr, 32'd0);
    idle(1);
    check("mul_gv_T4", obs_gv, 0);
    check("mul_hi_kept", hi, 32'hFFFF_FFFF);
    check("mul_lo_kept", lo, 32'hFFFF_FFFF);

    // flush at T+1 cancels, new MULT waits in DRAIN, then issues
    step(1, OP_MULT, 32'd7, 32'd9, 0, 1);
    step(0, 4'd0, 32'd0, 32'd0, 1, 1);
    check("flush_cancel_T1", obs_cancel, 1);
    step(1, OP_MULT, 32'd2, 32'd3, 0, 1);
    check("drain_stall_T2", obs_stall, 1);
    check("drain_cancel_T2", obs_cancel, 0);
    step(1, OP_MULT, 32'd2, 32'd3, 0, 1);
    check("drain_stall_T3", obs_stall, 1);
    check("drain_en_T3", obs_en, 0);
    check("flush_hi_kept", hi, 32'hFFFF_FFFF);
    step(1, OP_MULT, 32'd2, 32'd3, 0, 1);
    check("reissue_en_T4", obs_en, 1);
    idle(3);
    check("reissue_hi", hi, 32'd0);
    check("reissue_lo", lo, 32'd6);

    // MTHI behind a MULT
    step(1, OP_MULT, 32'd4, 32'd5, 0, 1);
    step(1, OP_MTHI, 32'h1234, 32'd0, 0, 1);
    step(1, OP_MTHI, 32'h1234, 32'd0, 0, 1);
    step(1, OP_MTHI, 32'h1234, 32'd0, 0, 1);
    check("mthi_stall_finish", obs_stall, 1);
    check("mthi_mult_hi", hi, 32'd0);
    check("mthi_mult_lo", lo, 32'h14);
    step(1, OP_MTHI, 32'h1234, 32'd0, 0, 1);
    check("mthi_release", obs_stall, 0);
    check("mthi_hi", hi, 32'h1234);

    // randomized phase; EX holds its op while stalled, as a pipeline would
    spur_on = 1'b1;
    hv = 0; ho = '0; ha = '0; hb = '0; hf = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!(m_stall_prev && !hf)) begin
        hv = ($urandom_range(0, 9) < 7);
        ho = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
        ha = rnd_val();
        hb = rnd_val();
      end
      hf = ($urandom_range(0, 11) == 0);
      rn = ($urandom_range(0, 299) != 0);
      step(hv, ho, ha, hb, hf, rn);
      if (!rn) m_stall_prev = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
